count_window_ctrl: RTL and testbench
====================================

# count_window_ctrl

Run controller for the BCD event counter in the muon-lifetime front end. It takes a start/stop request, clears the counter, enables it for a programmable gate window measured in millisecond ticks, then freezes it. It latches the final 4-digit BCD count into a held register for display and readout, and flags counter rollover and early stop. It sits between the debounced front-panel controls and the counter's reset/enable inputs.

## Interface
- `TICK_DIV`, 100000: clock cycles per gate tick (1 ms at 100 MHz); must be at least 2.
- `clk`  in  1  system clock, 100 MHz.
- `reset`  in  1  asynchronous, active-low reset of all state.
- `start`  in  1  debounced level; a rising edge requests a run.
- `stop`  in  1  debounced level; a high level ends a run early.
- `window_ms`  in  16  gate length in ticks; sampled on the accepted start edge; 0 means free run until `stop`.
- `counter_digits`  in  16  live BCD count from the event counter.
- `counter_reset`  out  1  clear strobe to the counter.
- `counter_enable`  out  1  enable to the counter.
- `held_digits`  out  16  BCD count latched at the end of the last run.
- `elapsed_ms`  out  16  ticks elapsed in the current or last run.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse when `held_digits` updates.
- `overflow`  out  1  sticky per run; the counter rolled 9999 to 0000 during the run.
- `truncated`  out  1  sticky per run; the run was ended by `stop`.

## Operation
- States: IDLE, CLEAR, RUN, DRAIN, LATCH.
- IDLE:
  - `counter_enable`=0, `counter_reset`=0.
  - A `start` rising edge (via an internal previous-value flop) with `stop`=0 moves to CLEAR. The same edge:
    - loads `window_ms` into the window register;
    - clears `elapsed_ms`, the prescaler, `overflow` and `truncated`.
  - A start edge with `stop`=1 is ignored.
- CLEAR:
  - Lasts exactly 1 cycle.
  - `counter_reset`=1, `counter_enable`=0.
  - Goes to RUN.
- RUN:
  - `counter_enable`=1.
  - Prescaler counts 0 to TICK_DIV-1 and wraps. On each wrap, `elapsed_ms` increments, saturating at 16'hFFFF.
  - Window end: the wrap that makes `elapsed_ms` equal the window register (window ≠ 0) moves to DRAIN.
  - `stop`=1 moves to DRAIN and sets `truncated`. Stop has priority over a window end in the same cycle.
  - Rollover detection: if `counter_digits` is less than its value one cycle earlier (unsigned compare), `overflow` is set. The first RUN cycle's comparison is masked.
  - Start edges are ignored.
- DRAIN:
  - Lasts 1 cycle.
  - `counter_enable`=0; the counter's final increment has settled.
  - Goes to LATCH.
- LATCH:
  - Lasts 1 cycle.
  - `held_digits` <= `counter_digits`; `done`=1.
  - Goes to IDLE.
- `held_digits`, `elapsed_ms`, `overflow` and `truncated` hold their values in IDLE until the next accepted start.
- Free run (window 0): the run ends only on `stop`. `elapsed_ms` saturates and does not wrap.

## Timing
- Reset values:
  - state IDLE;
  - all 1-bit outputs 0;
  - `held_digits`=16'h0000, `elapsed_ms`=0;
  - prescaler=0, start-previous flop=0.
- Reset assertion mid-run returns the block to IDLE immediately (asynchronously) with the values above. `counter_enable` drops without a DRAIN or LATCH cycle.
- The start edge is sampled at clock edge k; CLEAR is active in cycle k+1 and RUN begins at cycle k+2.
- RUN lasts exactly window×TICK_DIV cycles when no stop occurs.
- `stop` sampled high in RUN cycle j: `counter_enable` is low from cycle j+1.
- `done` and the new `held_digits` appear 2 cycles after `counter_enable` falls. `busy` falls in the same cycle.
- The next start edge is accepted in the first IDLE cycle after LATCH.
- `counter_reset` is a single-cycle pulse per accepted start and is never asserted in any other cycle.

## Test plan
- **Normal window.** TICK_DIV=10, window_ms=3; start edge; counter model fed 5 event edges during RUN.
  - `counter_enable` high for exactly 30 cycles.
  - `done` pulses with `held_digits`=16'h0005, `elapsed_ms`=3, `truncated`=0, `overflow`=0.
- **Early stop.** TICK_DIV=10, window_ms=100; `stop` raised 25 cycles into RUN.
  - `counter_enable` falls the next cycle.
  - `elapsed_ms`=2, `truncated`=1, `done` pulses 2 cycles after the fall.
- **Rollover.** Counter preset to reach 16'h9998, then 3 events during RUN.
  - `held_digits`=16'h0001, `overflow`=1.
- **Start ignored.** Start edges repeated during RUN, plus a start edge coincident with `stop`=1 in IDLE.
  - No extra `counter_reset` pulses; run length unchanged; no run begins in the coincident case.
- **Free run.** window_ms=0, TICK_DIV=2, stop withheld for 2^17+10 cycles.
  - `elapsed_ms` saturates at 16'hFFFF; the run ends only on `stop`.
- **Reset mid-run.** `reset` pulled low 7 cycles into RUN.
  - All outputs return to reset values asynchronously and `done` never pulses.
  - A subsequent start runs normally.

Source files
------------

// File: rtl/count_window_ctrl.sv
// rtl/count_window_ctrl.sv - run controller gating a BCD event counter for a tick-based window
module count_window_ctrl #(
    parameter int TICK_DIV = 100000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        stop,
    input  logic [15:0] window_ms,
    input  logic [15:0] counter_digits,
    output logic        counter_reset,
    output logic        counter_enable,
    output logic [15:0] held_digits,
    output logic [15:0] elapsed_ms,
    output logic        busy,
    output logic        done,
    output logic        overflow,
    output logic        truncated
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_RUN,
        S_DRAIN,
        S_LATCH
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        start_prev;
    logic        start_edge;
    logic        accept;
    logic        tick_wrap;
    logic        window_end;
    logic        cmp_armed;
    logic [PW-1:0] prescaler;
    logic [15:0] window_reg;
    logic [15:0] prev_digits;
    logic [15:0] elapsed_inc;

    assign start_edge  = start & ~start_prev;
    assign tick_wrap   = (prescaler == TICK_LAST);
    assign elapsed_inc = (elapsed_ms == 16'hFFFF) ? elapsed_ms : elapsed_ms + 16'd1;
    // A zero window never matches here, so free runs end only on stop.
    assign window_end  = tick_wrap && (window_reg != 16'd0) && (elapsed_inc == window_reg);

    // Next-state selection and state-decoded counter controls
    always_comb begin
        next_state     = state;
        accept         = 1'b0;
        counter_reset  = 1'b0;
        counter_enable = 1'b0;
        busy           = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start_edge && !stop) begin
                    accept     = 1'b1;
                    next_state = S_CLEAR;
                end
            end
            S_CLEAR: begin
                counter_reset = 1'b1;
                next_state    = S_RUN;
            end
            S_RUN: begin
                counter_enable = 1'b1;
                if (stop || window_end) begin
                    next_state = S_DRAIN;
                end
            end
            S_DRAIN: next_state = S_LATCH;
            S_LATCH: next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Start edge history and one-cycle-old count for rollover detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            start_prev  <= 1'b0;
            prev_digits <= 16'h0000;
            cmp_armed   <= 1'b0;
        end else begin
            start_prev  <= start;
            prev_digits <= counter_digits;
            // Previous sample is only meaningful once it was taken inside RUN.
            cmp_armed   <= (state == S_RUN);
        end
    end

    // Per-run window, tick prescaler, elapsed count and sticky flags
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            window_reg <= 16'd0;
            prescaler  <= '0;
            elapsed_ms <= 16'd0;
            overflow   <= 1'b0;
            truncated  <= 1'b0;
        end else if (accept) begin
            window_reg <= window_ms;
            prescaler  <= '0;
            elapsed_ms <= 16'd0;
            overflow   <= 1'b0;
            truncated  <= 1'b0;
        end else if (state == S_RUN) begin
            prescaler <= tick_wrap ? '0 : prescaler + 1'b1;
            if (tick_wrap) begin
                elapsed_ms <= elapsed_inc;
            end
            if (stop) begin
                truncated <= 1'b1;
            end
            if (cmp_armed && (counter_digits < prev_digits)) begin
                overflow <= 1'b1;
            end
        end
    end

    // Final count capture; done coincides with the new held value
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            held_digits <= 16'h0000;
            done        <= 1'b0;
        end else begin
            done <= (state == S_LATCH);
            if (state == S_LATCH) begin
                held_digits <= counter_digits;
            end
        end
    end

endmodule

// File: tb/tb_count_window_ctrl.sv
// tb/tb_count_window_ctrl.sv - directed self-checking bench for count_window_ctrl
module tb_count_window_ctrl;

    logic        clk;
    logic        reset;
    logic        start, stop;
    logic [15:0] window_ms;
    logic [15:0] counter_digits;
    logic        counter_reset, counter_enable, busy, done, overflow, truncated;
    logic [15:0] held_digits, elapsed_ms;

    logic        start2, stop2;
    logic [15:0] window2, digits2;
    logic        counter_reset2, counter_enable2, busy2, done2, overflow2, truncated2;
    logic [15:0] held2, elapsed2;

    logic        ev, load;
    logic [15:0] load_val;

    int evals = 0;
    int fails = 0;

    int cyc = 0, en_cnt = 0, rst_cnt = 0, done_cnt = 0, fall_cyc = 0, done_cyc = 0;
    logic prev_en = 1'b0;
    int en_base, rst_base, done_base;
    logic ok;

    count_window_ctrl #(.TICK_DIV(10)) dut (
        .clk(clk), .reset(reset), .start(start), .stop(stop), .window_ms(window_ms),
        .counter_digits(counter_digits), .counter_reset(counter_reset),
        .counter_enable(counter_enable), .held_digits(held_digits), .elapsed_ms(elapsed_ms),
        .busy(busy), .done(done), .overflow(overflow), .truncated(truncated)
    );

    count_window_ctrl #(.TICK_DIV(2)) dut2 (
        .clk(clk), .reset(reset), .start(start2), .stop(stop2), .window_ms(window2),
        .counter_digits(digits2), .counter_reset(counter_reset2),
        .counter_enable(counter_enable2), .held_digits(held2), .elapsed_ms(elapsed2),
        .busy(busy2), .done(done2), .overflow(overflow2), .truncated(truncated2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] bcd_inc(input logic [15:0] v);
        logic [15:0] r;
        logic        c;
        r = v;
        c = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (c) begin
                if (r[i*4 +: 4] == 4'd9) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return r;
    endfunction

    // Event counter model fed by the controller's reset/enable
    always @(posedge clk) begin
        if (counter_reset) counter_digits <= 16'h0000;
        else if (load) counter_digits <= load_val;
        else if (counter_enable && ev) counter_digits <= bcd_inc(counter_digits);
    end

    // Activity monitor sampled mid-cycle
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (counter_enable) en_cnt = en_cnt + 1;
        if (counter_reset) rst_cnt = rst_cnt + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
        if (prev_en && !counter_enable) fall_cyc = cyc;
        prev_en = counter_enable;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        evals++;
        assert (obs === exp)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_for(input int which, input int budget, input string tag);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            step();
            if ((which == 0 && counter_enable) || (which == 1 && done) ||
                (which == 2 && counter_enable2) || (which == 3 && done2)) begin
                ok = 1'b1;
                break;
            end
        end
        check(tag, ok, 1);
    endtask

    task automatic snap();
        en_base   = en_cnt;
        rst_base  = rst_cnt;
        done_base = done_cnt;
    endtask

    initial begin
        reset = 1'b0; start = 1'b0; stop = 1'b0; window_ms = 16'd0;
        start2 = 1'b0; stop2 = 1'b0; window2 = 16'd0; digits2 = 16'h0042;
        ev = 1'b0; load = 1'b0; load_val = 16'h0000;
        counter_digits = 16'h0000;
        repeat (3) step();
        check("rst_enable", counter_enable, 0);
        check("rst_creset", counter_reset, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_held", held_digits, 16'h0000);
        check("rst_elapsed", elapsed_ms, 0);
        check("rst_ovf", overflow, 0);
        check("rst_trunc", truncated, 0);
        reset = 1'b1;
        step();

        // Normal window: 3 ticks of 10 cycles, 5 events
        snap();
        window_ms = 16'd3; start = 1'b1;
        step();
        check("n_clear_pulse", counter_reset, 1);
        check("n_clear_busy", busy, 1);
        wait_for(0, 5, "n_wait_run");
        start = 1'b0; ev = 1'b1;
        repeat (5) step();
        ev = 1'b0;
        wait_for(1, 100, "n_wait_done");
        check("n_en_cycles", en_cnt - en_base, 30);
        check("n_rst_pulses", rst_cnt - rst_base, 1);
        check("n_held", held_digits, 16'h0005);
        check("n_elapsed", elapsed_ms, 3);
        check("n_trunc", truncated, 0);
        check("n_ovf", overflow, 0);
        check("n_busy_fall", busy, 0);
        check("n_done_lag", done_cyc - fall_cyc, 2);
        step();
        check("n_done_1cyc", done, 0);
        check("n_done_count", done_cnt - done_base, 1);

        // Early stop 25 cycles into RUN, 4 events
        snap();
        window_ms = 16'd100; start = 1'b1;
        wait_for(0, 5, "e_wait_run");
        start = 1'b0; ev = 1'b1;
        repeat (4) step();
        ev = 1'b0;
        repeat (21) step();
        stop = 1'b1;
        step();
        check("e_enable_fall", counter_enable, 0);
        stop = 1'b0;
        wait_for(1, 10, "e_wait_done");
        check("e_elapsed", elapsed_ms, 2);
        check("e_trunc", truncated, 1);
        check("e_ovf_masked", overflow, 0);
        check("e_held", held_digits, 16'h0004);
        check("e_en_cycles", en_cnt - en_base, 26);
        check("e_done_lag", done_cyc - fall_cyc, 2);

        // Rollover 9998 -> 9999 -> 0000 -> 0001, then back-to-back restart
        window_ms = 16'd3; start = 1'b1;
        wait_for(0, 5, "r_wait_run");
        start = 1'b0; load = 1'b1; load_val = 16'h9998;
        step();
        load = 1'b0; ev = 1'b1;
        repeat (3) step();
        ev = 1'b0;
        wait_for(1, 100, "r_wait_done");
        check("r_held", held_digits, 16'h0001);
        check("r_ovf", overflow, 1);
        check("r_trunc", truncated, 0);
        start = 1'b1;
        step();
        check("b2b_accept", counter_reset, 1);
        start = 1'b0;
        wait_for(1, 100, "b2b_wait_done");
        check("b2b_held", held_digits, 16'h0000);
        check("b2b_ovf_cleared", overflow, 0);

        // Start edges during RUN and a start coincident with stop in IDLE
        snap();
        start = 1'b1;
        wait_for(0, 5, "s_wait_run");
        step(); start = 1'b0;
        step(); start = 1'b1;
        step(); start = 1'b0;
        step(); start = 1'b1;
        step(); start = 1'b0;
        wait_for(1, 100, "s_wait_done");
        check("s_en_cycles", en_cnt - en_base, 30);
        check("s_rst_pulses", rst_cnt - rst_base, 1);
        step();
        stop = 1'b1; start = 1'b1;
        repeat (5) step();
        check("s_coinc_busy", busy, 0);
        check("s_coinc_rst", rst_cnt - rst_base, 1);
        start = 1'b0; stop = 1'b0;
        step();

        // Free run on the TICK_DIV=2 instance
        start2 = 1'b1;
        wait_for(2, 5, "f_wait_run");
        start2 = 1'b0;
        repeat (131082) step();
        check("f_elapsed_sat", elapsed2, 16'hFFFF);
        check("f_still_run", counter_enable2, 1);
        stop2 = 1'b1;
        wait_for(3, 10, "f_wait_done");
        stop2 = 1'b0;
        check("f_elapsed_end", elapsed2, 16'hFFFF);
        check("f_trunc", truncated2, 1);
        check("f_held", held2, 16'h0042);
        check("f_ovf", overflow2, 0);
        check("f_creset_idle", counter_reset2, 0);

        // Reset asserted 7 cycles into RUN
        snap();
        window_ms = 16'd3; start = 1'b1;
        wait_for(0, 5, "m_wait_run");
        start = 1'b0; ev = 1'b1;
        repeat (7) step();
        ev = 1'b0;
        #2 reset = 1'b0;
        #1;
        check("m_enable", counter_enable, 0);
        check("m_busy", busy, 0);
        check("m_creset", counter_reset, 0);
        check("m_done", done, 0);
        check("m_held", held_digits, 16'h0000);
        check("m_elapsed", elapsed_ms, 0);
        check("m_trunc", truncated, 0);
        repeat (3) step();
        reset = 1'b1;
        repeat (3) step();
        check("m_no_done", done_cnt - done_base, 0);
        snap();
        window_ms = 16'd2; start = 1'b1;
        wait_for(0, 5, "m2_wait_run");
        start = 1'b0; ev = 1'b1;
        repeat (2) step();
        ev = 1'b0;
        wait_for(1, 100, "m2_wait_done");
        check("m2_en_cycles", en_cnt - en_base, 20);
        check("m2_held", held_digits, 16'h0002);
        check("m2_elapsed", elapsed_ms, 2);

        $display("End of test - %0d assertions evaluated, %0d failures", evals, fails);
        $finish;
    end

endmodule
